debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel, parametrised switch/button debouncer for the lab board's front-panel inputs. Each channel synchronises an asynchronous raw input, filters it through a four-state debounce FSM with a loadable down-counter, and produces a clean level plus single-cycle rise, fall and optional auto-repeat ticks. Sits between the board pins and all control FSMs; downstream logic consumes only its registered outputs.

## Interface
- CHANNELS, 4: number of independent input channels (1..32).
- CNT_W, 21: debounce counter width; stable time LOAD = 2^CNT_W − 1 cycles.
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- REPEAT_CYCLES, 0: auto-repeat period in cycles while held high; 0 disables repeat logic entirely.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- sw  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- db_level  out  CHANNELS  debounced level per channel.
- rise_tick  out  CHANNELS  one-cycle pulse on committed 0→1.
- fall_tick  out  CHANNELS  one-cycle pulse on committed 1→0.
- repeat_tick  out  CHANNELS  one-cycle pulse every REPEAT_CYCLES while level held 1; constant 0 if REPEAT_CYCLES = 0.

## Operation
- Per channel: sw[i] → SYNC_STAGES-flop synchroniser → s[i]; FSM acts on s[i] only.
- States: ZERO, WAIT1, ONE, WAIT0.
- ZERO: s=1 → WAIT1, cnt ← LOAD. Else stay.
- WAIT1: s=0 → ZERO (glitch rejected, no tick). s=1 → cnt ← cnt−1; if cnt−1 == 0 → ONE.
- ONE: s=0 → WAIT0, cnt ← LOAD. Else stay.
- WAIT0: s=1 → ONE (no tick). s=0 → cnt ← cnt−1; if cnt−1 == 0 → ZERO.
- db_level = 1 in ONE and WAIT0, 0 in ZERO and WAIT1; registered (decoded from state register).
- rise_tick high for exactly the first cycle state = ONE after WAIT1; fall_tick likewise for ZERO after WAIT0. Returns WAIT1→ZERO / WAIT0→ONE never tick.
- Repeat: rep_cnt (width clog2(REPEAT_CYCLES+1)) clears to 0 whenever state ≠ ONE; in ONE increments each cycle; on reaching REPEAT_CYCLES pulses repeat_tick and reloads 0. First repeat tick thus REPEAT_CYCLES cycles after rise_tick. A WAIT0 bounce back to ONE restarts the repeat period.
- Counter arithmetic unsigned, CNT_W bits; cnt never underflows (commit happens at 1→0).
- Channels fully independent; simultaneous events on different channels all reported in the same cycle.

## Timing
- Reset (async assert, sync release): state ZERO, cnt 0, rep_cnt 0, synchroniser flops 0, db_level 0, all ticks 0.
- Latency, clean edge: sw change → s change after SYNC_STAGES cycles; FSM enters WAIT after 1 more cycle; commit LOAD cycles later. Total sw→db_level = SYNC_STAGES + 1 + LOAD cycles.
- Ticks are coincident with the db_level transition cycle, never wider than 1 cycle.
- Reset mid-wait: count discarded, channel returns to ZERO; if sw still high after release, a full new debounce and a rise_tick follow.
- Input toggling faster than LOAD cycles: level never changes, no ticks.

## Structure
- Shared package debounce_pkg: state encoding (ZERO=00, WAIT0=01, ONE=10, WAIT1=11) and a clog2 helper function.
- One sub-module debounce_channel (synchroniser, FSM, counter, repeat counter, tick regs), instantiated CHANNELS times in a generate loop by debounce_bank.

## Test plan
- CNT_W=3 (LOAD=7), ch0 sw 0→1 held: db_level[0] rises exactly SYNC_STAGES+8 cycles later, rise_tick[0] one cycle, no other channel activity.
- ch1 pulse of 4 cycles (< LOAD): db_level[1] stays 0, no rise/fall tick.
- Held high ch0, then 3-cycle low glitch: WAIT0→ONE, db_level stays 1, no fall_tick; true release yields fall_tick after SYNC_STAGES+8 cycles.
- REPEAT_CYCLES=5, ch2 held 20 cycles after commit: repeat_tick[2] at 5,10,15,20 cycles after rise_tick; none after release.
- Reset asserted mid-WAIT1 on ch3: all outputs 0 immediately; release with sw high → full debounce, one rise_tick.
- All 4 channels asserted same cycle: all db_level bits and rise_ticks assert in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the front-panel debouncer: channel FSM encoding and
// a ceil(log2) helper for sizing counters from parameters.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_WAIT0 = 2'b01,
    ST_ONE   = 2'b10,
    ST_WAIT1 = 2'b11
  } state_t;

  // Smallest r with 2**r >= v; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Bundle of raw switch inputs and the debounced level/tick outputs for all
// channels of a debounce_bank.
interface debounce_bank_if #(
  parameter int unsigned CHANNELS = 4
);

  logic [CHANNELS-1:0] sw;
  logic [CHANNELS-1:0] db_level;
  logic [CHANNELS-1:0] rise_tick;
  logic [CHANNELS-1:0] fall_tick;
  logic [CHANNELS-1:0] repeat_tick;

  modport master (
    output sw,
    input  db_level, rise_tick, fall_tick, repeat_tick
  );

  modport slave (
    input  sw,
    output db_level, rise_tick, fall_tick, repeat_tick
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, four-state filter FSM with a
// loadable down-counter, registered level/edge ticks and optional auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = 21,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic repeat_tick
);

  localparam logic [CNT_W-1:0] LOAD = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_dec;

  // Synchroniser: s is the only view of sw the FSM ever sees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_dec = cnt_q - CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ZERO;
      cnt_q     <= '0;
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_level  <= (state_d == ST_ONE) || (state_d == ST_WAIT0);
      rise_tick <= (state_q == ST_WAIT1) && (state_d == ST_ONE);
      fall_tick <= (state_q == ST_WAIT0) && (state_d == ST_ZERO);
    end
  end

  // Commit happens when the count would reach zero, so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ZERO: begin
        if (s) begin
          state_d = ST_WAIT1;
          cnt_d   = LOAD;
        end
      end
      ST_WAIT1: begin
        if (!s) begin
          state_d = ST_ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (!s) begin
          state_d = ST_WAIT0;
          cnt_d   = LOAD;
        end
      end
      ST_WAIT0: begin
        if (s) begin
          state_d = ST_ONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = ST_ZERO;
        end
      end
      default: begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  if (REPEAT_CYCLES > 0) begin : g_rep
    localparam int unsigned REP_W = clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_q, rep_inc;
    logic             tick_q;

    assign rep_inc     = rep_q + REP_W'(1);
    assign repeat_tick = tick_q;

    // Period restarts on every entry into ONE, including WAIT0 bounces.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rep_q  <= '0;
        tick_q <= 1'b0;
      end else if (state_q != ST_ONE) begin
        rep_q  <= '0;
        tick_q <= 1'b0;
      end else if (rep_inc == REP_W'(REPEAT_CYCLES)) begin
        rep_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        rep_q  <= rep_inc;
        tick_q <= 1'b0;
      end
    end
  end else begin : g_no_rep
    assign repeat_tick = 1'b0;
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels for the front-panel inputs.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned CNT_W         = 21,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input logic            clk,
  input logic            reset,
  debounce_bank_if.slave bus
);

  logic [CHANNELS-1:0] level, rise, fall, rep;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .CNT_W        (CNT_W),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sw         (bus.sw[i]),
      .db_level   (level[i]),
      .rise_tick  (rise[i]),
      .fall_tick  (fall[i]),
      .repeat_tick(rep[i])
    );
  end

  assign bus.db_level    = level;
  assign bus.rise_tick   = rise;
  assign bus.fall_tick   = fall;
  assign bus.repeat_tick = rep;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with LOAD = 7, two sync stages and a
// five-cycle repeat period.
module tb_debounce_bank;

  localparam int unsigned CH    = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned REP   = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  debounce_bank_if #(.CHANNELS(CH)) bus();

  debounce_bank #(
    .CHANNELS     (CH),
    .CNT_W        (CNT_W),
    .SYNC_STAGES  (SYNC),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    int         n;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    // sw, cycles to wait, expected level / rise / fall after the wait
    tbl[0]  = '{4'b0001, 1,  4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 8,  4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0001, 1,  4'b0001, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0001, 1,  4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0011, 4,  4'b0001, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 12, 4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 9,  4'b0001, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0001};
    tbl[8]  = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1111, 9,  4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1111, 1,  4'b1111, 4'b1111, 4'b0000};
    tbl[11] = '{4'b1111, 1,  4'b1111, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 9,  4'b1111, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b1111};
    tbl[14] = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0000};

    reset  = 1'b1;
    bus.sw = 4'b0000;
    step();
    step();
    chk("reset level", bus.db_level, 4'b0000);
    chk("reset rise", bus.rise_tick, 4'b0000);
    chk("reset fall", bus.fall_tick, 4'b0000);
    chk("reset repeat", bus.repeat_tick, 4'b0000);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bus.sw = tbl[i].sw;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d level", i), bus.db_level, tbl[i].lvl);
      chk($sformatf("vec%0d rise", i), bus.rise_tick, tbl[i].rise);
      chk($sformatf("vec%0d fall", i), bus.fall_tick, tbl[i].fall);
    end

    // ch0: short low glitch while held must bounce WAIT0 -> ONE silently
    bus.sw = 4'b0001;
    repeat (12) step();
    chk("glitch pre level", bus.db_level, 4'b0001);
    bus.sw = 4'b0000;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3) bus.sw = 4'b0001;
      chk($sformatf("glitch k=%0d level", k), bus.db_level, 4'b0001);
      chk($sformatf("glitch k=%0d fall", k), bus.fall_tick, 4'b0000);
    end
    bus.sw = 4'b0000;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("release k=%0d level", k), bus.db_level, (k < 10) ? 4'b0001 : 4'b0000);
      chk($sformatf("release k=%0d fall", k), bus.fall_tick, (k == 10) ? 4'b0001 : 4'b0000);
    end

    // ch2: auto-repeat every 5 cycles after rise, none once released
    reset  = 1'b1;
    bus.sw = 4'b0000;
    step();
    reset  = 1'b0;
    bus.sw = 4'b0100;
    repeat (10) step();
    chk("rep rise", bus.rise_tick, 4'b0100);
    chk("rep rise repeat", bus.repeat_tick, 4'b0000);
    for (int k = 1; k <= 35; k++) begin
      step();
      chk($sformatf("rep k=%0d repeat", k), bus.repeat_tick,
          (k <= 20 && (k % 5) == 0) ? 4'b0100 : 4'b0000);
      chk($sformatf("rep k=%0d level", k), bus.db_level, (k < 30) ? 4'b0100 : 4'b0000);
      chk($sformatf("rep k=%0d fall", k), bus.fall_tick, (k == 30) ? 4'b0100 : 4'b0000);
      if (k == 20) bus.sw = 4'b0000;
    end

    // ch3: reset in the middle of WAIT1 discards the count
    bus.sw = 4'b0001;
    repeat (10) step();
    chk("pre-reset level", bus.db_level, 4'b0001);
    bus.sw = 4'b1001;
    repeat (5) step();
    #3;
    reset = 1'b1;
    #1;
    chk("mid reset level", bus.db_level, 4'b0000);
    chk("mid reset rise", bus.rise_tick, 4'b0000);
    chk("mid reset fall", bus.fall_tick, 4'b0000);
    chk("mid reset repeat", bus.repeat_tick, 4'b0000);
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("post reset k=%0d level", k), bus.db_level, (k >= 10) ? 4'b1001 : 4'b0000);
      chk($sformatf("post reset k=%0d rise", k), bus.rise_tick, (k == 10) ? 4'b1001 : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
